// File: rtl/mult_sched_pkg.sv
// Shared constants and helpers for the round-robin multiplier scheduler.
package mult_sched_pkg;

  localparam int DEF_SIZE  = 4;
  localparam int DEF_LEVEL = 2;
  localparam int DEF_NREQ  = 4;

  // Ceiling log2; values of 1 or less give 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/mult_tag_pipe.sv
// Valid+ID shift register that tracks issued operations through the multiplier.
module mult_tag_pipe #(
  parameter int DEPTH = 3,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] tag_in,
  output logic [W-1:0] tag_out
);

  logic [DEPTH-1:0][W-1:0] stage_q, stage_d;

  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = tag_in;
    for (int k = 1; k < DEPTH; k++) stage_d[k] = stage_q[k-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stage_q <= '0;
    else        stage_q <= stage_d;
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/pipelined_multiplier.sv
// Unsigned multiplier: one input register followed by LEVEL output register stages.
module pipelined_multiplier #(
  parameter int SIZE  = 4,
  parameter int LEVEL = 2
) (
  input  logic              clk,
  input  logic [SIZE-1:0]   a,
  input  logic [SIZE-1:0]   b,
  output logic [2*SIZE-1:0] pdt
);

  logic [SIZE-1:0]                a_q, b_q;
  logic [LEVEL-1:0][2*SIZE-1:0]   pipe_q, pipe_d;

  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = (2*SIZE)'(a_q) * (2*SIZE)'(b_q);
    for (int k = 1; k < LEVEL; k++) pipe_d[k] = pipe_q[k-1];
  end

  // Deliberately unreset: the scheduler's tag pipe decides what is valid.
  always_ff @(posedge clk) begin
    a_q    <= a;
    b_q    <= b;
    pipe_q <= pipe_d;
  end

  assign pdt = pipe_q[LEVEL-1];

endmodule

// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler sharing one pipelined multiplier among NREQ requesters.
module mult_rr_scheduler
  import mult_sched_pkg::*;
#(
  parameter  int SIZE  = DEF_SIZE,
  parameter  int LEVEL = DEF_LEVEL,
  parameter  int NREQ  = DEF_NREQ,
  localparam int LAT   = LEVEL + 1,
  localparam int IDW   = clog2(NREQ),
  localparam int CW    = clog2(LAT + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*SIZE-1:0] a_flat,
  input  logic [NREQ*SIZE-1:0] b_flat,
  output logic [NREQ-1:0]      gnt,
  output logic [SIZE-1:0]      mul_a,
  output logic [SIZE-1:0]      mul_b,
  input  logic [2*SIZE-1:0]    mul_pdt,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [2*SIZE-1:0]    rsp_pdt,
  output logic [CW-1:0]        inflight
);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  inflight_q, inflight_d;
  logic [IDW-1:0] gnt_idx;
  logic           gnt_any;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    // Search begins just past the last winner so it drops to lowest priority.
    for (int k = 1; k <= NREQ; k++) begin
      if (!gnt_any && req[(int'(ptr_q) + k) % NREQ]) begin
        gnt_any = 1'b1;
        gnt_idx = IDW'((int'(ptr_q) + k) % NREQ);
      end
    end
    gnt   = gnt_any ? (NREQ'(1) << gnt_idx) : '0;
    mul_a = gnt_any ? a_flat[gnt_idx*SIZE +: SIZE] : '0;
    mul_b = gnt_any ? b_flat[gnt_idx*SIZE +: SIZE] : '0;
    ptr_d = gnt_any ? gnt_idx : ptr_q;

    inflight_d = inflight_q;
    case ({gnt_any, rsp_valid})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= IDW'(NREQ - 1);
      inflight_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      inflight_q <= inflight_d;
    end
  end

  mult_tag_pipe #(
    .DEPTH (LAT),
    .W     (IDW + 1)
  ) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  ({gnt_any, gnt_idx}),
    .tag_out ({rsp_valid, rsp_id})
  );

  assign rsp_pdt  = mul_pdt;
  assign inflight = inflight_q;

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Directed and scoreboarded checks of mult_rr_scheduler driving a pipelined_multiplier.
module tb_mult_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  req = '0;
  logic [15:0] a_flat = '0, b_flat = '0;
  logic [3:0]  gnt;
  logic [3:0]  mul_a, mul_b;
  logic [7:0]  mul_pdt;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_pdt;
  logic [1:0]  inflight;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mult_rr_scheduler #(.SIZE(4), .LEVEL(2), .NREQ(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_flat(a_flat), .b_flat(b_flat),
    .gnt(gnt), .mul_a(mul_a), .mul_b(mul_b), .mul_pdt(mul_pdt),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_pdt(rsp_pdt), .inflight(inflight)
  );

  pipelined_multiplier #(.SIZE(4), .LEVEL(2)) u_mul (
    .clk(clk), .a(mul_a), .b(mul_b), .pdt(mul_pdt)
  );

  task automatic apply_reset();
    req = '0; a_flat = '0; b_flat = '0;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1 rst_n = 1'b0; req = 4'b0000;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset rsp_valid got %b exp 0", rsp_valid); end
    checks++; if (inflight !== 2'd0) begin failures++; $display("FAIL reset inflight got %0d exp 0", inflight); end
    checks++; if (gnt !== 4'b0000 || mul_a !== 4'd0 || mul_b !== 4'd0) begin
      failures++; $display("FAIL reset idle gnt=%b mul_a=%0d mul_b=%0d exp 0/0/0", gnt, mul_a, mul_b); end
    req = 4'b1111; #1;
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL reset first_priority got %b exp 0001", gnt); end
    @(posedge clk); #1 rst_n = 1'b1; req = '0;
  endtask

  task automatic test_single();
    int rq [7]  = '{1, 1, 1, 0, 0, 0, 0};
    int inf [7] = '{0, 1, 2, 3, 2, 1, 0};
    int vld [7] = '{0, 0, 0, 1, 1, 1, 0};
    apply_reset();
    a_flat = 16'h0003; b_flat = 16'h0005;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1 req = 4'(rq[c]);
      @(negedge clk);
      checks++; if (gnt !== 4'(rq[c])) begin failures++; $display("FAIL single gnt c%0d got %b exp %b", c+1, gnt, 4'(rq[c])); end
      checks++; if (rsp_valid !== 1'(vld[c])) begin failures++; $display("FAIL single rsp_valid c%0d got %b exp %0d", c+1, rsp_valid, vld[c]); end
      checks++; if (inflight !== 2'(inf[c])) begin failures++; $display("FAIL single inflight c%0d got %0d exp %0d", c+1, inflight, inf[c]); end
      if (vld[c] == 1) begin
        checks++; if (rsp_id !== 2'd0 || rsp_pdt !== 8'd15) begin
          failures++; $display("FAIL single rsp c%0d got id=%0d pdt=%0d exp 0/15", c+1, rsp_id, rsp_pdt); end
      end
      if (c == 0) begin
        checks++; if (mul_a !== 4'd3 || mul_b !== 4'd5) begin
          failures++; $display("FAIL single operands got %0d,%0d exp 3,5", mul_a, mul_b); end
      end
    end
  endtask

  task automatic test_saturation();
    int pdt [4] = '{1, 4, 9, 225};
    apply_reset();
    a_flat = 16'hF321; b_flat = 16'hF321;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1 req = 4'b1111;
      @(negedge clk);
      checks++; if (gnt !== (4'b0001 << ((c-1) % 4))) begin
        failures++; $display("FAIL sat gnt c%0d got %b exp %b", c, gnt, 4'b0001 << ((c-1) % 4)); end
      checks++; if (inflight !== 2'((c-1) > 3 ? 3 : c-1)) begin
        failures++; $display("FAIL sat inflight c%0d got %0d exp %0d", c, inflight, (c-1) > 3 ? 3 : c-1); end
      checks++; if (rsp_valid !== (c >= 4)) begin
        failures++; $display("FAIL sat rsp_valid c%0d got %b exp %0d", c, rsp_valid, c >= 4); end
      if (c >= 4) begin
        checks++; if (rsp_id !== 2'((c-4) % 4) || rsp_pdt !== 8'(pdt[(c-4) % 4])) begin
          failures++; $display("FAIL sat rsp c%0d got id=%0d pdt=%0d exp %0d/%0d", c, rsp_id, rsp_pdt, (c-4) % 4, pdt[(c-4) % 4]); end
      end
    end
    @(posedge clk); #1 req = '0;
  endtask

  task automatic test_priority_wrap();
    apply_reset();
    a_flat = 16'h4321; b_flat = 16'h1111;
    @(posedge clk); #1 req = 4'b0100;
    @(negedge clk);
    checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL wrap first got %b exp 0100", gnt); end
    @(posedge clk); #1 req = 4'b1010;
    @(negedge clk);
    checks++; if (gnt !== 4'b1000 || mul_a !== 4'd4) begin
      failures++; $display("FAIL wrap second got gnt=%b mul_a=%0d exp 1000/4", gnt, mul_a); end
    @(posedge clk); #1 req = 4'b1010;
    @(negedge clk);
    checks++; if (gnt !== 4'b0010 || mul_a !== 4'd2) begin
      failures++; $display("FAIL wrap third got gnt=%b mul_a=%0d exp 0010/2", gnt, mul_a); end
    @(posedge clk); #1 req = '0;
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    a_flat = 16'h0023; b_flat = 16'h0075;
    @(posedge clk); #1 req = 4'b0001;
    @(negedge clk);
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL midrst g0 got %b exp 0001", gnt); end
    @(posedge clk); #1 req = 4'b0010;
    @(negedge clk);
    checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL midrst g1 got %b exp 0010", gnt); end
    @(posedge clk); #1 req = 4'b0000;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin
      failures++; $display("FAIL midrst pre_rsp got v=%b id=%0d exp 1/0", rsp_valid, rsp_id); end
    rst_n = 1'b0; #1;
    checks++; if (rsp_valid !== 1'b0 || inflight !== 2'd0) begin
      failures++; $display("FAIL midrst async got v=%b inflight=%0d exp 0/0", rsp_valid, inflight); end
    @(posedge clk); #1 rst_n = 1'b1; req = 4'b1111;
    @(negedge clk);
    checks++; if (gnt !== 4'b0001 || rsp_valid !== 1'b0) begin
      failures++; $display("FAIL midrst post gnt=%b v=%b exp 0001/0", gnt, rsp_valid); end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1 req = 4'b0000;
      @(negedge clk);
      if (c < 2) begin
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL midrst stale c%0d got v=1 exp 0", c); end
      end else begin
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_pdt !== 8'd15) begin
          failures++; $display("FAIL midrst new_rsp got v=%b id=%0d pdt=%0d exp 1/0/15", rsp_valid, rsp_id, rsp_pdt); end
      end
    end
  endtask

  task automatic test_gaps();
    apply_reset();
    a_flat = 16'h0063; b_flat = 16'h0075;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1 req = (c == 1) ? 4'b0001 : (c == 3) ? 4'b0010 : 4'b0000;
      @(negedge clk);
      if (c == 2) begin
        checks++; if (gnt !== 4'b0000 || mul_a !== 4'd0 || mul_b !== 4'd0) begin
          failures++; $display("FAIL gaps idle got gnt=%b a=%0d b=%0d exp 0/0/0", gnt, mul_a, mul_b); end
      end
      if (c == 4) begin
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_pdt !== 8'd15) begin
          failures++; $display("FAIL gaps rsp4 got v=%b id=%0d pdt=%0d exp 1/0/15", rsp_valid, rsp_id, rsp_pdt); end
      end
      if (c == 5) begin
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL gaps rsp5 got v=1 exp 0"); end
      end
      if (c == 6) begin
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_pdt !== 8'd42) begin
          failures++; $display("FAIL gaps rsp6 got v=%b id=%0d pdt=%0d exp 1/1/42", rsp_valid, rsp_id, rsp_pdt); end
      end
    end
  endtask

  typedef struct { int id; int pdt; int due; } ent_t;

  task automatic test_random();
    ent_t sb [$];
    bit   pend [4];
    int   pa [4], pb [4], waitc [4];
    int   gi;
    apply_reset();
    for (int i = 0; i < 4; i++) begin pend[i] = 0; waitc[i] = 0; end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && ($urandom_range(1, 0) == 1)) begin
          pend[i] = 1; pa[i] = $urandom_range(15, 0); pb[i] = $urandom_range(15, 0); waitc[i] = 0;
        end
        req[i] = pend[i];
        a_flat[i*4 +: 4] = 4'(pa[i]);
        b_flat[i*4 +: 4] = 4'(pb[i]);
      end
      @(negedge clk);
      checks++; if (int'(inflight) != sb.size()) begin
        failures++; $display("FAIL rand inflight cyc%0d got %0d exp %0d", cyc, inflight, sb.size()); end
      if (rsp_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL rand spurious_rsp cyc%0d got id=%0d exp none", cyc, rsp_id);
        end else begin
          if (sb[0].due != cyc || int'(rsp_id) != sb[0].id || int'(rsp_pdt) != sb[0].pdt) begin
            failures++; $display("FAIL rand rsp cyc%0d got id=%0d pdt=%0d exp id=%0d pdt=%0d due=%0d",
                                 cyc, rsp_id, rsp_pdt, sb[0].id, sb[0].pdt, sb[0].due); end
          void'(sb.pop_front());
        end
      end else if (sb.size() > 0 && sb[0].due == cyc) begin
        checks++; failures++;
        $display("FAIL rand missing_rsp cyc%0d got v=%b exp id=%0d", cyc, rsp_valid, sb[0].id);
        void'(sb.pop_front());
      end
      gi = -1;
      for (int i = 0; i < 4; i++) if (gnt[i] === 1'b1) gi = i;
      checks++;
      if (req == 4'b0000) begin
        if (gnt !== 4'b0000) begin failures++; $display("FAIL rand idle_gnt cyc%0d got %b exp 0000", cyc, gnt); end
      end else if ($countones(gnt) != 1 || (gnt & ~req) != 4'b0000) begin
        failures++; $display("FAIL rand gnt cyc%0d got %b req %b exp one-hot within req", cyc, gnt, req);
      end else if (int'(mul_a) != pa[gi] || int'(mul_b) != pb[gi]) begin
        failures++; $display("FAIL rand operands cyc%0d got %0d,%0d exp %0d,%0d", cyc, mul_a, mul_b, pa[gi], pb[gi]);
      end
      if (gi >= 0 && req != 4'b0000) begin
        sb.push_back('{id: gi, pdt: pa[gi] * pb[gi], due: cyc + 3});
        pend[gi] = 0;
      end
      for (int i = 0; i < 4; i++) begin
        if (pend[i]) begin
          waitc[i]++;
          if (waitc[i] > 3) begin
            checks++; failures++;
            $display("FAIL rand starve cyc%0d req%0d waited %0d exp <=3", cyc, i, waitc[i]);
            waitc[i] = 0;
          end
        end
      end
    end
    @(posedge clk); #1 req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_saturation();
    test_priority_wrap();
    test_reset_midflight();
    test_gaps();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
